hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Second-generation pipeline hazard controller for the 5-stage MIPS core.
- Provides:
  - operand forwarding into D and E, with generic register address width;
  - load-use, branch and jr interlocks;
  - an internal iterative-divider busy sequencer, replacing the external stall_divE input;
  - an exception flush sequencer that defers a flush across cache wait states.
- Sits beside the datapath and drives every stage's stall/flush enables.

Parameters:
- AW, 5, register address width; address 0 is never forwarded or interlocked.
- DIV_CYCLES, 33, cycles the divider occupies E (minimum 2).
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- regwriteE, regwriteM, regwriteW  in  1 each  stage writes GPR
- memtoRegE, memtoRegM  in  1 each  stage holds a load
- branchD, jrD  in  1 each  D holds branch / jr
- rsD, rtD, rsE, rtE  in  AW each  source register addresses
- waddrE, waddrM, waddrW  in  AW each  destination addresses
- div_startE  in  1  E holds div/divu
- i_stall, d_stall  in  1 each  cache wait
- except_flush  in  1  exception/eret commit pulse from M
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold stage register
- flushD, flushE, flushM  out  1 each  bubble stage register
- forwardAD, forwardBD  out  1 each  D compare operand from M
- forwardAE, forwardBE  out  2 each  10 = from M, 01 = from W, 00 = register file
- div_busy  out  1  divider sequencer not IDLE
- div_doneE  out  1  quotient/remainder valid for HI/LO write
- longest_stall  out  1  pipeline-internal stall (not memory)

Behaviour:
- Reset (resetn low, async):
  - div_state = IDLE, flush_pend = 0.
  - Consequently div_busy = 0 and div_doneE = 0.
  - Combinational outputs follow inputs.
- Forwarding (combinational):
  - M has priority over W.
  - Match requires a nonzero address and the corresponding regwrite.
  - forwardAD/BD use M only.
- lw_stall = memtoRegE & waddrE != 0 & (rsD == waddrE | rtD == waddrE).
- br_stall = (branchD | jrD) & (a or b below), with addresses nonzero:
  - (a) regwriteE & (rsD or rtD == waddrE);
  - (b) memtoRegM & (rsD or rtD == waddrM).
- Divider FSM (IDLE → BUSY → DONE):
  - IDLE → BUSY: on div_startE & !except_flush & !mem_stall; load cnt = DIV_CYCLES-2.
  - BUSY: cnt decrements every cycle, including during mem_stall. At cnt == 0, go to DONE.
  - DONE: div_doneE = 1. Hold DONE while mem_stall; go to IDLE on the first cycle with !mem_stall.
  - div_doneE therefore rises exactly DIV_CYCLES cycles after start acceptance.
  - stall_div = (IDLE & div_startE) | BUSY.
  - except_flush in any state forces IDLE next edge.
- mem_stall = i_stall | d_stall.
- Exception sequencer:
  - eff_flush = (except_flush | flush_pend) & !mem_stall.
  - If except_flush & mem_stall: flush_pend <= 1.
  - flush_pend clears on the edge where eff_flush = 1.
  - A second except_flush while pending is absorbed, not counted twice.
- Outputs:
  - int_stall = lw_stall | br_stall | stall_div.
  - stallF = stallD = (int_stall | mem_stall) & !eff_flush.
  - stallE = (stall_div | mem_stall) & !eff_flush.
  - stallM = stallW = mem_stall.
  - flushD = eff_flush.
  - flushE = eff_flush | ((lw_stall | br_stall) & !mem_stall).
  - flushM = eff_flush.
  - longest_stall = int_stall.
- Flush dominates interlock stall in the same cycle; a memory stall dominates flush, which is deferred.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds ports stall_cnt (out, PERF_W) and flush_cnt (out, PERF_W), both reset to 0.
  - stall_cnt increments every cycle stallD = 1.
  - flush_cnt increments on every edge where eff_flush = 1.
  - Both wrap modulo 2^PERF_W.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the div_state_t enum (IDLE, BUSY, DONE);
  - the AW default.
- One sub-module, hazard_div_seq: divider FSM plus counter, outputs stall_div and div_doneE.

Test Plan:
- Forwarding: rsE = 3, waddrM = 3, regwriteM = 1, waddrW = 3, regwriteW = 1 → forwardAE = 10. Same with regwriteM = 0 → 01. Same with rsE = 0 → 00.
- Load-use: memtoRegE = 1, waddrE = 8, rtD = 8 → stallF = stallD = flushE = 1 and stallE = 0 for one cycle. Next cycle memtoRegE = 0 → all 0.
- Divider, DIV_CYCLES = 33: div_startE at cycle t →
  - stallE = 1 for cycles t..t+32;
  - div_doneE = 1 at t+33 with stallE = 0;
  - div_busy falls at t+34.
  - Repeat with d_stall at t+33 for 3 cycles → DONE held, div_doneE high for 4 cycles.
- Deferred flush: except_flush pulse while i_stall = 1 for 5 cycles → flushD/E/M = 0 during the wait, then 1 for exactly one cycle when i_stall drops. A second pulse while pending yields no extra flush.
- Flush during divide: except_flush at cnt = 10 → div_busy = 0 next cycle, stallE = 0, flushE = 1.
- Reset mid-divide: resetn low asynchronously at cnt = 5 → div_busy = 0 and flush_pend = 0 immediately. With HAZARD_PERF_EN defined, stall_cnt = flush_cnt = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the MIPS core hazard logic: forwarding select codes,
// divider sequencer states and the default register address width.
package cpu_pkg;

  localparam int AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // M wins over W when both stages write the same source register.
  function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
    if (hitM)      return FWD_M;
    else if (hitW) return FWD_W;
    else           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_div_seq.sv
// Iterative divider occupancy sequencer: holds E while the divide runs and
// flags the single result cycle (held across memory wait states).
module hazard_div_seq
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic resetn,
  input  logic divStart,
  input  logic exceptFlush,
  input  logic memStall,
  output logic stallDiv,
  output logic divDone,
  output logic divBusy
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;

  div_state_t    state, nextState;
  logic [CW-1:0] cnt, cntNext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    stallDiv  = 1'b0;
    divDone   = 1'b0;
    divBusy   = (state != IDLE);
    case (state)
      IDLE: begin
        stallDiv = divStart;
        if (divStart && !memStall) begin
          nextState = BUSY;
          cntNext   = CW'(DIV_CYCLES - 2);
        end
      end
      BUSY: begin
        stallDiv = 1'b1;
        // The divide runs on regardless of memory stalls.
        if (cnt == '0) nextState = DONE;
        else           cntNext   = cnt - CW'(1);
      end
      DONE: begin
        divDone = 1'b1;
        if (!memStall) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (exceptFlush) nextState = IDLE;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: forwarding, interlocks, divider
// sequencing and deferred exception flush. HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DIV_CYCLES = 33
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W     = 32
`endif
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoRegE,
  input  logic          memtoRegM,
  input  logic          branchD,
  input  logic          jrD,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] waddrE,
  input  logic [AW-1:0] waddrM,
  input  logic [AW-1:0] waddrW,
  input  logic          div_startE,
  input  logic          i_stall,
  input  logic          d_stall,
  input  logic          except_flush,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          forwardAD,
  output logic          forwardBD,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          div_busy,
  output logic          div_doneE,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
`endif
  output logic          longest_stall
);

  logic memStall, effFlush, flushPend;
  logic lwStall, brStall, stallDiv, intStall;
  logic rsDnz, rtDnz, rsEnz, rtEnz;
  logic hitAEM, hitAEW, hitBEM, hitBEW;
  logic dHitE, dHitM;

  assign memStall = i_stall | d_stall;
  assign effFlush = (except_flush | flushPend) & ~memStall;

  // A flush that lands during a cache wait is remembered until the wait ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          flushPend <= 1'b0;
    else if (effFlush)                    flushPend <= 1'b0;
    else if (except_flush && memStall)    flushPend <= 1'b1;
  end

  assign rsDnz = (rsD != '0);
  assign rtDnz = (rtD != '0);
  assign rsEnz = (rsE != '0);
  assign rtEnz = (rtE != '0);

  assign hitAEM = rsEnz & regwriteM & (rsE == waddrM);
  assign hitAEW = rsEnz & regwriteW & (rsE == waddrW);
  assign hitBEM = rtEnz & regwriteM & (rtE == waddrM);
  assign hitBEW = rtEnz & regwriteW & (rtE == waddrW);

  assign forwardAE = fwdSel(hitAEM, hitAEW);
  assign forwardBE = fwdSel(hitBEM, hitBEW);
  assign forwardAD = rsDnz & regwriteM & (rsD == waddrM);
  assign forwardBD = rtDnz & regwriteM & (rtD == waddrM);

  assign dHitE = (waddrE != '0) & ((rsD == waddrE) | (rtD == waddrE));
  assign dHitM = (waddrM != '0) & ((rsD == waddrM) | (rtD == waddrM));

  assign lwStall = memtoRegE & dHitE;
  // Branch operands are compared in D, so any in-flight producer in E or a load in M blocks it.
  assign brStall = (branchD | jrD) & ((regwriteE & dHitE) | (memtoRegM & dHitM));

  hazard_div_seq #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk         (clk),
    .resetn      (resetn),
    .divStart    (div_startE),
    .exceptFlush (except_flush),
    .memStall    (memStall),
    .stallDiv    (stallDiv),
    .divDone     (div_doneE),
    .divBusy     (div_busy)
  );

  assign intStall = lwStall | brStall | stallDiv;

  assign stallF        = (intStall | memStall) & ~effFlush;
  assign stallD        = stallF;
  assign stallE        = (stallDiv | memStall) & ~effFlush;
  assign stallM        = memStall;
  assign stallW        = memStall;
  assign flushD        = effFlush;
  assign flushE        = effFlush | ((lwStall | brStall) & ~memStall);
  assign flushM        = effFlush;
  assign longest_stall = intStall;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallD)   stall_cnt <= stall_cnt + PERF_W'(1);
      if (effFlush) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int AW  = 5;
  localparam int DIV = 33;

  logic clk = 1'b0;
  logic resetn;
  logic regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM, branchD, jrD;
  logic [AW-1:0] rsD, rtD, rsE, rtE, waddrE, waddrM, waddrW;
  logic div_startE, i_stall, d_stall, except_flush;
  logic stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM;
  logic forwardAD, forwardBD, div_busy, div_doneE, longest_stall;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(AW), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .resetn(resetn),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM), .branchD(branchD), .jrD(jrD),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .waddrE(waddrE), .waddrM(waddrM), .waddrW(waddrW),
    .div_startE(div_startE), .i_stall(i_stall), .d_stall(d_stall),
    .except_flush(except_flush),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .div_busy(div_busy), .div_doneE(div_doneE),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .longest_stall(longest_stall)
  );

  wire [16:0] obsVec = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM,
                        forwardAD, forwardBD, forwardAE, forwardBE,
                        div_busy, div_doneE, longest_stall};

  int errors = 0;
  int checks = 0;

  // Model state: mDiv counts cycles since the divide was accepted (0 = idle).
  int          mDiv;
  bit          mPend;
  int unsigned mStallCnt, mFlushCnt;
  logic [16:0] expVec;
  bit          expEff, expStallD, expMem;

  function automatic logic [1:0] fwdCode(input logic [AW-1:0] a);
    if (a != 0 && regwriteM && a == waddrM) return 2'b10;
    if (a != 0 && regwriteW && a == waddrW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset;
    mDiv = 0; mPend = 0; mStallCnt = 0; mFlushCnt = 0;
  endtask

  task automatic modelEval;
    bit lw, br, sdiv, busy, done, istall, sD, sE, fE, aD, bD;
    expMem = i_stall || d_stall;
    expEff = (except_flush || mPend) && !expMem;
    lw = memtoRegE && waddrE != 0 && (rsD == waddrE || rtD == waddrE);
    br = (branchD || jrD) &&
         ((regwriteE && waddrE != 0 && (rsD == waddrE || rtD == waddrE)) ||
          (memtoRegM && waddrM != 0 && (rsD == waddrM || rtD == waddrM)));
    busy = (mDiv > 0);
    done = (mDiv >= DIV);
    sdiv = (mDiv == 0 && div_startE) || (busy && !done);
    istall = lw || br || sdiv;
    sD = (istall || expMem) && !expEff;
    sE = (sdiv || expMem) && !expEff;
    fE = expEff || ((lw || br) && !expMem);
    aD = rsD != 0 && regwriteM && rsD == waddrM;
    bD = rtD != 0 && regwriteM && rtD == waddrM;
    expStallD = sD;
    expVec = {sD, sD, sE, expMem, expMem, expEff, fE, expEff, aD, bD,
              fwdCode(rsE), fwdCode(rtE), busy, done, istall};
  endtask

  task automatic modelStep;
    if (expEff) mPend = 0;
    else if (except_flush && expMem) mPend = 1;
    if (except_flush)   mDiv = 0;
    else if (mDiv == 0) mDiv = (div_startE && !expMem) ? 1 : 0;
    else if (mDiv < DIV) mDiv++;
    else if (!expMem)   mDiv = 0;
    mStallCnt += expStallD;
    mFlushCnt += expEff;
  endtask

  task automatic clearInputs;
    {regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM, branchD, jrD} = '0;
    {rsD, rtD, rsE, rtE, waddrE, waddrM, waddrW} = '0;
    {div_startE, i_stall, d_stall, except_flush} = '0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    clearInputs();
    modelReset();
    #1;
    checks++;
    if (obsVec !== 17'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obsVec, 17'b0);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    resetn = 1'b1;
    #1; modelEval();
    checks++;
    if (obsVec !== expVec) begin
      errors++; $display("FAIL post_reset: got %b want %b", obsVec, expVec);
    end
    modelStep();
  endtask

  task automatic test_forwarding;
    logic [AW-1:0] rsEv[4] = '{5'd3, 5'd3, 5'd0, 5'd0};
    logic [AW-1:0] rtEv[4] = '{5'd0, 5'd0, 5'd0, 5'd3};
    logic [AW-1:0] rsDv[4] = '{5'd0, 5'd0, 5'd0, 5'd3};
    logic          rwMv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]    eAE[4]  = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0]    eBE[4]  = '{2'b00, 2'b00, 2'b00, 2'b10};
    logic          eAD[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clearInputs();
      rsE = rsEv[i]; rtE = rtEv[i]; rsD = rsDv[i];
      waddrM = 5'd3; waddrW = 5'd3; regwriteM = rwMv[i]; regwriteW = 1'b1;
      #1; modelEval();
      checks++;
      if ({forwardAE, forwardBE, forwardAD} !== {eAE[i], eBE[i], eAD[i]}) begin
        errors++;
        $display("FAIL fwd_case%0d: got AE=%b BE=%b AD=%b want AE=%b BE=%b AD=%b",
                 i, forwardAE, forwardBE, forwardAD, eAE[i], eBE[i], eAD[i]);
      end
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("FAIL fwd_model%0d: got %b want %b", i, obsVec, expVec);
      end
      modelStep();
    end
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clearInputs();
      memtoRegE = (i == 0); regwriteE = (i == 0);
      waddrE = 5'd8; rtD = 5'd8;
      #1; modelEval();
      checks++;
      if ({stallF, stallD, flushE, stallE} !== ((i == 0) ? 4'b1110 : 4'b0000)) begin
        errors++;
        $display("FAIL load_use%0d: got sF/sD/fE/sE=%b want %b", i,
                 {stallF, stallD, flushE, stallE}, (i == 0) ? 4'b1110 : 4'b0000);
      end
      modelStep();
    end
  endtask

  task automatic test_divider(input int memHold);
    int doneLast;
    doneLast = DIV + memHold;
    for (int k = 0; k <= doneLast + 1; k++) begin
      @(negedge clk);
      clearInputs();
      div_startE = (k < DIV);
      d_stall = (k >= DIV && k < DIV + memHold);
      #1; modelEval();
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("FAIL div%0d_model k=%0d: got %b want %b", memHold, k, obsVec, expVec);
      end
      if (k < DIV) begin
        checks++;
        if ({stallE, div_doneE} !== 2'b10) begin
          errors++; $display("FAIL div%0d_busy k=%0d: got sE/done=%b want 10", memHold, k, {stallE, div_doneE});
        end
      end else if (k <= doneLast) begin
        checks++;
        if ({div_doneE, div_busy} !== 2'b11 || (memHold == 0 && stallE !== 1'b0)) begin
          errors++;
          $display("FAIL div%0d_done k=%0d: got done/busy/sE=%b%b%b want 11 and sE=0 without stall",
                   memHold, k, div_doneE, div_busy, stallE);
        end
      end else begin
        checks++;
        if ({div_doneE, div_busy} !== 2'b00) begin
          errors++; $display("FAIL div%0d_idle k=%0d: got done/busy=%b want 00", memHold, k, {div_doneE, div_busy});
        end
      end
      modelStep();
    end
  endtask

  task automatic test_deferred_flush;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clearInputs();
      i_stall = (k < 5);
      except_flush = (k == 0 || k == 2);
      #1; modelEval();
      checks++;
      if ({flushD, flushE, flushM} !== ((k == 5) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL deferred_flush k=%0d: got %b want %b", k, {flushD, flushE, flushM},
                 (k == 5) ? 3'b111 : 3'b000);
      end
      modelStep();
    end
  endtask

  task automatic test_flush_div;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      clearInputs();
      div_startE = (k <= 22);
      except_flush = (k == 22);
      #1; modelEval();
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("FAIL flush_div_model k=%0d: got %b want %b", k, obsVec, expVec);
      end
      if (k == 22) begin
        checks++;
        if ({flushE, stallE} !== 2'b10) begin
          errors++; $display("FAIL flush_div_now: got fE/sE=%b want 10", {flushE, stallE});
        end
      end else if (k == 23) begin
        checks++;
        if ({div_busy, stallE} !== 2'b00) begin
          errors++; $display("FAIL flush_div_after: got busy/sE=%b want 00", {div_busy, stallE});
        end
      end
      modelStep();
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      clearInputs();
      div_startE = 1'b1;
      #1; modelEval(); modelStep();
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({div_busy, div_doneE} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_div: got busy/done=%b want 00", {div_busy, div_doneE});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    clearInputs();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      i_stall = 1'b1;
      except_flush = (k == 0);
      #1; modelEval(); modelStep();
    end
    #1 resetn = 1'b0;
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    clearInputs();
    #1; modelEval();
    checks++;
    if ({flushD, flushE, flushM} !== 3'b000) begin
      errors++; $display("FAIL reset_clears_pend: got %b want 000", {flushD, flushE, flushM});
    end
    modelStep();
  endtask

  task automatic test_random;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      regwriteE = $urandom_range(0, 1); regwriteM = $urandom_range(0, 1);
      regwriteW = $urandom_range(0, 1);
      memtoRegE = ($urandom_range(0, 3) == 0); memtoRegM = ($urandom_range(0, 3) == 0);
      branchD = ($urandom_range(0, 6) == 0); jrD = ($urandom_range(0, 9) == 0);
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      waddrE = AW'($urandom_range(0, 3)); waddrM = AW'($urandom_range(0, 3));
      waddrW = AW'($urandom_range(0, 3));
      i_stall = ($urandom_range(0, 9) == 0); d_stall = ($urandom_range(0, 9) == 0);
      except_flush = ($urandom_range(0, 29) == 0);
      div_startE = (mDiv > 0 && mDiv < DIV) ? 1'b1 : ($urandom_range(0, 7) == 0);
      #1; modelEval();
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("FAIL random n=%0d: got %b want %b", n, obsVec, expVec);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cnt !== mStallCnt || flush_cnt !== mFlushCnt) begin
        errors++;
        $display("FAIL random_cnt n=%0d: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt,
                 mStallCnt, mFlushCnt);
      end
`endif
      modelStep();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_divider(0);
    test_divider(3);
    test_deferred_flush();
    test_flush_div();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
